// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Purpose:
//   Transmit side of the UART. Sends one byte per frame on TXD in this order:
//   start bit (0), DATA_BITS data bits LSB first, an optional parity bit, and a
//   stop bit (1). Every bit is held for OVERSAMPLE clk cycles, so clk is the
//   same 16x tick the receiver samples with. A one-entry holding buffer behind
//   a valid/ready handshake lets frames run back to back with no idle gap.
//
// Ports:
//   clk       in   1          clock; all bit timing is counted in clk cycles
//   reset     in   1          asynchronous, active-high
//   tx_valid  in   1          tx_data is being offered
//   tx_data   in   DATA_BITS  byte to send; captured when tx_valid && tx_ready
//   tx_ready  out  1          holding buffer is empty
//   TXD       out  1          serial line, idles high, registered
//   tx_busy   out  1          frame in progress, registered
//   tx_done   out  1          one-cycle pulse in the last cycle of a stop bit
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 TXD,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_sampleCnt;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [DATA_BITS-1:0] r_buf;
  logic                 r_bufFull;
  logic                 r_txd;
  logic                 r_busy;
  logic                 r_done;

  logic w_cntEnd;
  logic w_accept;
  logic w_load;
  logic w_parity;

  // w_load is the single point where the buffered byte moves into the shift
  // register: either straight from IDLE, or at the end of a stop bit so the
  // next start bit follows with no idle cycle. Accept and load are mutually
  // exclusive because one needs an empty buffer and the other a full one.
  assign w_cntEnd = (r_sampleCnt == CNT_LAST);
  assign w_accept = tx_valid && !r_bufFull;
  assign w_load   = r_bufFull && ((r_state == S_IDLE) ||
                                  ((r_state == S_STOP) && w_cntEnd));
  assign w_parity = (PARITY_ODD != 0) ? ~^r_buf : ^r_buf;
  assign tx_ready = ~r_bufFull;

  // Holding buffer: filled by the handshake, emptied when the FSM copies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bufFull <= 1'b0;
      r_buf     <= '0;
    end else if (w_accept) begin
      r_bufFull <= 1'b1;
      r_buf     <= tx_data;
    end else if (w_load) begin
      r_bufFull <= 1'b0;
    end
  end

  // Frame sequencer. Each state lasts exactly OVERSAMPLE cycles; the sample
  // counter reloads to zero on every state change and never wraps on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sampleCnt <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sampleCnt <= '0;
          if (w_load) begin
            r_state  <= S_START;
            r_shift  <= r_buf;
            r_parity <= w_parity;
          end
        end
        S_START: begin
          if (w_cntEnd) begin
            r_state     <= S_DATA;
            r_bitIdx    <= '0;
            r_sampleCnt <= '0;
          end else begin
            r_sampleCnt <= r_sampleCnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_cntEnd) begin
            r_sampleCnt <= '0;
            if (r_bitIdx == IDX_LAST) begin
              r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bitIdx <= r_bitIdx + IDX_W'(1);
            end
          end else begin
            r_sampleCnt <= r_sampleCnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_cntEnd) begin
            r_state     <= S_STOP;
            r_sampleCnt <= '0;
          end else begin
            r_sampleCnt <= r_sampleCnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_cntEnd) begin
            r_sampleCnt <= '0;
            if (w_load) begin
              r_state  <= S_START;
              r_shift  <= r_buf;
              r_parity <= w_parity;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_sampleCnt <= r_sampleCnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_sampleCnt <= '0;
        end
      endcase
    end
  end

  // Line and status flops. They follow the sequencer state one cycle later,
  // which is why TXD drops two edges after the accepting edge, and it keeps
  // tx_done lined up with the last cycle of the stop bit as seen on TXD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   r_txd <= 1'b1;
        S_START:  r_txd <= 1'b0;
        S_DATA:   r_txd <= r_shift[r_bitIdx];
        S_PARITY: r_txd <= r_parity;
        S_STOP:   r_txd <= 1'b1;
        default:  r_txd <= 1'b1;
      endcase
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_STOP) && w_cntEnd;
    end
  end

  assign TXD     = r_txd;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Purpose:
//   Drives three transmitters from one producer: even parity, odd parity and
//   no parity. Each accepted byte is turned into an expected frame (start time
//   plus line pattern) and queued; a monitor records the line every cycle and,
//   on each tx_done pulse, pops the oldest expectation and compares the whole
//   frame, the done timing and tx_busy.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int OS   = 16;
  localparam int NDUT = 3;
  localparam int MAXC = 65536;

  typedef struct {
    int b;
    int s;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       drvValid;
  logic [7:0] txData;
  logic [2:0] acc;
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] txd;
  logic [2:0] busy;
  logic [2:0] done;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   lastEnd  [NDUT];
  int   occUntil [NDUT];
  int   readyErr [NDUT];
  rec_t expQ     [NDUT][$];
  logic hist     [NDUT][MAXC];
  logic busyH    [NDUT][MAXC];

  assign vld = {3{drvValid}} & ~acc;

  always #5 clk = ~clk;

  uart_transmitter #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .tx_valid(vld[0]), .tx_data(txData), .tx_ready(rdy[0]),
    .TXD(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_transmitter #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
    .clk(clk), .reset(reset), .tx_valid(vld[1]), .tx_data(txData), .tx_ready(rdy[1]),
    .TXD(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_transmitter #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
    .clk(clk), .reset(reset), .tx_valid(vld[2]), .tx_data(txData), .tx_ready(rdy[2]),
    .TXD(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  // Configuration of each instance, and the frame it should put on the line.
  function automatic int pen(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic int podd(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int nbits(input int k);
    return 10 + pen(k);
  endfunction

  function automatic logic expBit(input int k, input int b, input int j);
    int par;
    par = ($countones(b[7:0]) % 2) ^ podd(k);
    if (j == 0) return 1'b0;
    if (j <= 8) return logic'((b >> (j - 1)) & 1);
    if (j == 9 && pen(k) != 0) return logic'(par);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compares one finished frame: idle/stop level just before it, every line
  // sample inside it, busy throughout, and the cycle of the done pulse.
  task automatic checkFrame(input int k, input rec_t r, input int t);
    int len;
    int errs;
    int idx;
    len  = nbits(k) * OS;
    errs = 0;
    if (r.s < 1 || r.s + len > MAXC) begin
      errs++;
    end else begin
      if (hist[k][r.s-1] !== 1'b1) errs++;
      for (int j = 0; j < nbits(k); j++) begin
        for (int i = 0; i < OS; i++) begin
          idx = r.s + j * OS + i;
          if (hist[k][idx] !== expBit(k, r.b, j)) errs++;
          if (busyH[k][idx] !== 1'b1) errs++;
        end
      end
    end
    tests++;
    if (errs != 0 || t != r.s + len - 1) begin
      fails++;
      $display("[TB] FAIL frame dut%0d byte %02h: done at cycle %0d, expected %0d; %0d bad samples, expected 0",
               k, r.b[7:0], t, r.s + len - 1, errs);
    end
  endtask

  // Scoreboard side: at each rising edge log accepted bytes with the start
  // time the line should show; at the following falling edge record the line
  // and check any frame the DUT reports as finished.
  initial begin
    int   start;
    rec_t r;
    for (int k = 0; k < NDUT; k++) begin
      lastEnd[k] = 0;
      occUntil[k] = 0;
      readyErr[k] = 0;
    end
    acc = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        for (int k = 0; k < NDUT; k++) begin
          expQ[k].delete();
          lastEnd[k] = 0;
          occUntil[k] = 0;
        end
        acc <= '0;
      end else if (!drvValid) begin
        acc <= '0;
      end else begin
        for (int k = 0; k < NDUT; k++) begin
          if (vld[k] && rdy[k]) begin
            start = (cyc + 2 > lastEnd[k]) ? cyc + 2 : lastEnd[k];
            r.b = int'(txData);
            r.s = start;
            expQ[k].push_back(r);
            lastEnd[k] = start + nbits(k) * OS;
            occUntil[k] = start - 1;
            acc[k] <= 1'b1;
          end
        end
      end
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (cyc < MAXC) begin
          hist[k][cyc]  = txd[k];
          busyH[k][cyc] = busy[k];
        end
        if (rdy[k] !== logic'(cyc >= occUntil[k])) readyErr[k]++;
        if (done[k] === 1'b1) begin
          if (expQ[k].size() == 0) begin
            checkOutput($sformatf("unexpected done dut%0d", k), 32'd1, 32'd0);
          end else begin
            r = expQ[k].pop_front();
            checkFrame(k, r, cyc);
          end
        end
      end
    end
  end

  // Offers one byte to all three DUTs and holds it until each has taken it;
  // with wobble set the data keeps changing while the producer waits.
  task automatic applyStimulus(input logic [7:0] b, input bit wobble);
    int waited;
    waited = 0;
    @(negedge clk);
    txData   = b;
    drvValid = 1'b1;
    @(negedge clk);
    while (acc !== 3'b111 && waited < 600) begin
      if (wobble) txData = 8'($urandom);
      @(negedge clk);
      waited++;
    end
    checkOutput("handshake accepted", {29'd0, acc}, 32'd7);
    drvValid = 1'b0;
  endtask

  // Waits for every queued frame to complete, then checks the line is idle.
  task automatic drainAndCheck();
    int waited;
    waited = 0;
    while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("frames pending", 32'(expQ[0].size() + expQ[1].size() + expQ[2].size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle busy", {29'd0, busy}, 32'd0);
    checkOutput("idle txd", {29'd0, txd}, 32'd7);
  endtask

  task automatic checkResetState();
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("reset state dut%0d", k),
                  {28'd0, txd[k], rdy[k], busy[k], done[k]}, 32'hC);
    end
  endtask

  // Directed cases first, then a long run of random bytes with random gaps.
  initial begin
    reset    = 1'b1;
    drvValid = 1'b0;
    txData   = 8'h00;
    repeat (3) @(negedge clk);
    checkResetState();
    #2 reset = 1'b0;

    applyStimulus(8'hA5, 1'b0);
    drainAndCheck();

    applyStimulus(8'h07, 1'b0);
    drainAndCheck();

    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    drainAndCheck();

    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b1);
    drainAndCheck();

    applyStimulus(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkResetState();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    applyStimulus(8'h81, 1'b0);
    drainAndCheck();

    for (int n = 0; n < 256; n++) begin
      applyStimulus(8'($urandom), 1'b0);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(150, 250)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drainAndCheck();

    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("ready tracking dut%0d", k), 32'(readyErr[k]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
